// File: rtl/iic_master.sv
// I2C master byte engine: START / byte write or read with ACK / STOP, driving open-drain pad
// enables. SCL runs at 4*QTR_DIV clocks per bit and honours slave clock stretching.
module iic_master #(
    parameter int unsigned QTR_DIV = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_rw,
    input  logic       cmd_nack,
    input  logic       cmd_nodata,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       ack_err,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, HOLD} state_t;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(QTR_DIV - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       phase;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       wdata;
    logic             r_stop, r_rw, r_nack, r_nodata, from_hold;
    logic             tick, stretch, accept;

    assign tick      = (cnt == CntLast);
    assign stretch   = (phase == 2'd1) && !scl_oe && !scl_i;
    assign cmd_ready = (state == IDLE) || (state == HOLD);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Pad enables {scl_oe, sda_oe} for a given state and quarter. For BIT/ACK the SDA level is
    // fixed for the whole cell, so the caller passes it in as sd.
    function automatic logic [1:0] pads(state_t st, logic [1:0] ph, logic fh, logic sd);
        logic scl_low;
        scl_low = (ph == 2'd0) || (ph == 2'd3);
        case (st)
            START:    pads = {((ph == 2'd0) ? fh : (ph == 2'd3)), ph[1]};
            BIT, ACK: pads = {scl_low, sd};
            STOP:     pads = {(ph == 2'd0), ~ph[1]};
            HOLD:     pads = 2'b10;
            default:  pads = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            phase      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            wdata      <= '0;
            r_stop     <= 1'b0;
            r_rw       <= 1'b0;
            r_nack     <= 1'b0;
            r_nodata   <= 1'b0;
            from_hold  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ack_err    <= 1'b0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (cmd_ready) begin
                cnt   <= '0;
                phase <= '0;
                if (accept) begin
                    wdata     <= din;
                    r_stop    <= cmd_stop;
                    r_rw      <= cmd_rw;
                    r_nack    <= cmd_nack;
                    r_nodata  <= cmd_nodata;
                    ack_err   <= 1'b0;
                    bit_idx   <= 3'd7;
                    from_hold <= (state == HOLD);
                    // In IDLE any data command needs a START to own the bus first.
                    if (cmd_start || (state == IDLE && !cmd_nodata)) begin
                        state             <= START;
                        {scl_oe, sda_oe}  <= pads(START, 2'd0, state == HOLD, 1'b0);
                    end else if (state == HOLD && !cmd_nodata) begin
                        state             <= BIT;
                        {scl_oe, sda_oe}  <= pads(BIT, 2'd0, 1'b0, ~cmd_rw & ~din[7]);
                    end else if (state == HOLD && cmd_stop) begin
                        state             <= STOP;
                        {scl_oe, sda_oe}  <= pads(STOP, 2'd0, 1'b0, 1'b0);
                    end
                end
            end else if (stretch) begin
                cnt <= '0;
            end else if (!tick) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                if (phase != 2'd3) begin
                    phase            <= phase + 2'd1;
                    {scl_oe, sda_oe} <= pads(state, phase + 2'd1, from_hold, sda_oe);
                    if (phase == 2'd2 && state == BIT) begin
                        shreg <= {shreg[6:0], sda_i};
                    end
                    if (phase == 2'd2 && state == ACK && !r_rw && sda_i) begin
                        ack_err <= 1'b1;
                    end
                end else begin
                    phase <= 2'd0;
                    case (state)
                        START: begin
                            if (!r_nodata) begin
                                state            <= BIT;
                                {scl_oe, sda_oe} <= pads(BIT, 2'd0, 1'b0, ~r_rw & ~wdata[7]);
                            end else if (r_stop) begin
                                state            <= STOP;
                                {scl_oe, sda_oe} <= pads(STOP, 2'd0, 1'b0, 1'b0);
                            end else begin
                                state            <= HOLD;
                                {scl_oe, sda_oe} <= pads(HOLD, 2'd0, 1'b0, 1'b0);
                            end
                        end
                        BIT: begin
                            if (bit_idx == 3'd0) begin
                                state            <= ACK;
                                {scl_oe, sda_oe} <= pads(ACK, 2'd0, 1'b0, r_rw & ~r_nack);
                            end else begin
                                bit_idx          <= bit_idx - 3'd1;
                                {scl_oe, sda_oe} <= pads(BIT, 2'd0, 1'b0,
                                                         ~r_rw & ~wdata[bit_idx - 3'd1]);
                            end
                        end
                        ACK: begin
                            if (r_rw) begin
                                dout       <= shreg;
                                dout_valid <= 1'b1;
                            end
                            if (r_stop) begin
                                state            <= STOP;
                                {scl_oe, sda_oe} <= pads(STOP, 2'd0, 1'b0, 1'b0);
                            end else begin
                                state            <= HOLD;
                                {scl_oe, sda_oe} <= pads(HOLD, 2'd0, 1'b0, 1'b0);
                            end
                        end
                        default: begin
                            state            <= IDLE;
                            {scl_oe, sda_oe} <= 2'b00;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_iic_master.sv
// Bench for iic_master: a per-cycle pad waveform model plus a bus-level monitor that decodes
// START/STOP/bytes, with a slave model driven from the same expected schedule.
module tb_iic_master;

    localparam int Q = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_rw = 1'b0;
    logic       cmd_nack = 1'b0, cmd_nodata = 1'b0;
    logic [7:0] din = 8'h00;
    logic       cmd_ready, dout_valid, ack_err, busy, scl_oe, sda_oe, scl_i, sda_i;
    logic [7:0] dout;
    logic       slave_pull = 1'b0, stretch = 1'b0;

    assign scl_i = !scl_oe && !stretch;
    assign sda_i = !sda_oe && !slave_pull;

    iic_master #(.QTR_DIV(Q), .CNT_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_rw(cmd_rw), .cmd_nack(cmd_nack),
        .cmd_nodata(cmd_nodata), .din(din), .dout(dout), .dout_valid(dout_valid),
        .ack_err(ack_err), .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_i(scl_i), .sda_i(sda_i)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       scl;
        logic       sda;
        logic       sl;
        logic       st;
        logic       ae;
        logic       dv;
        logic [7:0] dval;
    } ent_t;

    ent_t       exp_q[$];
    logic       rest_hold = 1'b0, ae_rest = 1'b0, dv_pend = 1'b0;
    logic [7:0] dv_val = 8'h00, exp_dout = 8'h00;
    logic       m_ae = 1'b0, m_dv = 1'b0;
    logic [7:0] m_dval = 8'h00;
    int         n_tests = 0, n_fail = 0;
    bit         chk_en = 1'b0;
    int         mon_starts = 0, mon_stops = 0, mon_nb = 0, dv_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    logic [8:0] mon_q[$];
    logic       pscl = 1'b1, psda = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
        end
    endtask

    // One quarter of an SCL cell: Q cycles, plus ext leading cycles of slave stretching.
    task automatic push_q(input logic scl, input logic sda, input logic sl, input int ext);
        ent_t e;
        for (int i = 0; i < Q + ext; i++) begin
            e.scl = scl; e.sda = sda; e.sl = sl; e.st = (i < ext);
            e.ae = m_ae; e.dv = m_dv; e.dval = m_dval;
            m_dv = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic model_cmd(input logic st, input logic sp, input logic rw, input logic nk,
                             input logic nd, input logic [7:0] d, input logic snack,
                             input logic [7:0] rdb, input int sbit);
        logic s, sl;
        m_ae = 1'b0;
        m_dv = 1'b0;
        if (nd && !st && (!rest_hold || !sp)) begin
            ae_rest = 1'b0;
            return;
        end
        if (st || !rest_hold) begin
            push_q(rest_hold, 1'b0, 1'b0, 0);
            push_q(1'b0, 1'b0, 1'b0, 0);
            push_q(1'b0, 1'b1, 1'b0, 0);
            push_q(1'b1, 1'b1, 1'b0, 0);
        end
        if (!nd) begin
            for (int i = 7; i >= 0; i--) begin
                s  = rw ? 1'b0 : !d[i];
                sl = rw ? !rdb[i] : 1'b0;
                push_q(1'b1, s, sl, 0);
                push_q(1'b0, s, sl, (i == sbit) ? 10 : 0);
                push_q(1'b0, s, sl, 0);
                push_q(1'b1, s, sl, 0);
            end
            s  = rw ? !nk : 1'b0;
            sl = rw ? 1'b0 : !snack;
            push_q(1'b1, s, sl, 0);
            push_q(1'b0, s, sl, 0);
            push_q(1'b0, s, sl, 0);
            m_ae = !rw && snack;
            push_q(1'b1, s, sl, 0);
            if (rw) begin
                m_dv = 1'b1;
                m_dval = rdb;
            end
        end
        if (sp) begin
            push_q(1'b1, 1'b1, 1'b0, 0);
            push_q(1'b0, 1'b1, 1'b0, 0);
            push_q(1'b0, 1'b0, 1'b0, 0);
            push_q(1'b0, 1'b0, 1'b0, 0);
            rest_hold = 1'b0;
        end else begin
            rest_hold = 1'b1;
        end
        ae_rest = m_ae;
        if (m_dv) begin
            dv_pend = 1'b1;
            dv_val = m_dval;
            m_dv = 1'b0;
        end
    endtask

    // Per-cycle compare, slave/stretch drive and bus monitor.
    always @(negedge clock) begin
        ent_t e;
        logic exp_rdy, exp_busy, bscl, bsda;
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_rdy = 1'b0;
                exp_busy = 1'b1;
            end else begin
                e.scl = rest_hold; e.sda = 1'b0; e.sl = 1'b0; e.st = 1'b0;
                e.ae = ae_rest; e.dv = dv_pend; e.dval = dv_val;
                dv_pend = 1'b0;
                exp_rdy = 1'b1;
                exp_busy = rest_hold;
            end
            if (e.dv) exp_dout = e.dval;
            slave_pull = e.sl;
            stretch = e.st;
            check("scl_oe", scl_oe, e.scl);
            check("sda_oe", sda_oe, e.sda);
            check("cmd_ready", cmd_ready, exp_rdy);
            check("busy", busy, exp_busy);
            check("ack_err", ack_err, e.ae);
            check("dout_valid", dout_valid, e.dv);
            check("dout", dout, exp_dout);
            if (dout_valid) dv_cnt++;
            bscl = !scl_oe && !e.st;
            bsda = !sda_oe && !e.sl;
            if (pscl && bscl && psda && !bsda) begin
                mon_starts++;
                mon_nb = 0;
            end
            if (pscl && bscl && !psda && bsda) mon_stops++;
            if (!pscl && bscl) begin
                if (mon_nb < 8) mon_byte = {mon_byte[6:0], bsda};
                else mon_q.push_back({bsda, mon_byte});
                mon_nb = (mon_nb == 8) ? 0 : mon_nb + 1;
            end
            pscl = bscl;
            psda = bsda;
        end
    end

    task automatic issue(input logic st, input logic sp, input logic rw, input logic nk,
                         input logic nd, input logic [7:0] d, input logic snack,
                         input logic [7:0] rdb, input int sbit);
        @(negedge clock);
        cmd_start = st; cmd_stop = sp; cmd_rw = rw; cmd_nack = nk; cmd_nodata = nd; din = d;
        cmd_valid = 1'b1;
        @(posedge clock);
        model_cmd(st, sp, rw, nk, nd, d, snack, rdb, sbit);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            #1 lat++;
        end while (!cmd_ready && lat < 2000);
    endtask

    task automatic mon_pop(output logic [8:0] v);
        if (mon_q.size() > 0) v = mon_q.pop_front();
        else v = 9'h1ff;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int lat, s0;
        logic [8:0] mb;
        repeat (3) @(posedge clock);
        #1;
        check("rst scl_oe", scl_oe, 0);
        check("rst sda_oe", sda_oe, 0);
        check("rst busy", busy, 0);
        check("rst cmd_ready", cmd_ready, 1);
        check("rst dout", dout, 0);
        check("rst ack_err", ack_err, 0);
        @(negedge clock);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Write 0xAA with START, slave ACKs, end in HOLD.
        issue(1, 0, 0, 0, 0, 8'hAA, 0, 8'h00, -1);
        wait_ready(lat);
        check("t1 latency", lat, 80);
        mon_pop(mb);
        check("t1 byte+ack", mb, {1'b0, 8'hAA});
        check("t1 starts", mon_starts, 1);
        check("t1 hold busy", busy, 1);

        // Continue without START, then standalone STOP, then an ignored nodata command.
        issue(0, 0, 0, 0, 0, 8'h55, 0, 8'h00, -1);
        wait_ready(lat);
        check("t2 latency", lat, 72);
        mon_pop(mb);
        check("t2 byte+ack", mb, {1'b0, 8'h55});
        check("t2 starts", mon_starts, 1);
        issue(0, 1, 0, 0, 1, 8'h00, 0, 8'h00, -1);
        wait_ready(lat);
        check("t2 stop latency", lat, 8);
        check("t2 stops", mon_stops, 1);
        check("t2 idle busy", busy, 0);
        issue(0, 1, 0, 0, 1, 8'h00, 0, 8'h00, -1);
        wait_ready(lat);
        check("t2 ignored latency", lat, 1);

        // Read 0x3C with NACK and STOP.
        dv_cnt = 0;
        issue(1, 1, 1, 1, 0, 8'h00, 0, 8'h3C, -1);
        wait_ready(lat);
        check("t3 latency", lat, 88);
        mon_pop(mb);
        check("t3 byte+nack", mb, {1'b1, 8'h3C});
        check("t3 dout", dout, 8'h3C);
        check("t3 dv pulses", dv_cnt, 1);
        check("t3 stops", mon_stops, 2);

        // Slave NACKs a write of 0xA0.
        issue(1, 1, 0, 0, 0, 8'hA0, 1, 8'h00, -1);
        wait_ready(lat);
        check("t4 latency", lat, 88);
        check("t4 ack_err", ack_err, 1);
        mon_pop(mb);
        check("t4 byte+nack", mb, {1'b1, 8'hA0});

        // Stretch 10 clocks in bit 3; ack_err cleared at acceptance.
        issue(1, 1, 0, 0, 0, 8'h96, 0, 8'h00, 3);
        check("t5 ack_err cleared", ack_err, 0);
        wait_ready(lat);
        check("t5 latency", lat, 98);
        mon_pop(mb);
        check("t5 byte+ack", mb, {1'b0, 8'h96});

        // Write, repeated START, reset during bit 5.
        issue(1, 0, 0, 0, 0, 8'h11, 0, 8'h00, -1);
        wait_ready(lat);
        check("t6 latency", lat, 80);
        mon_pop(mb);
        check("t6 byte+ack", mb, {1'b0, 8'h11});
        s0 = mon_starts;
        issue(1, 0, 0, 0, 0, 8'hC3, 0, 8'h00, -1);
        repeat (26) @(posedge clock);
        check("t6 repeated start", mon_starts, s0 + 1);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        exp_q.delete();
        rest_hold = 1'b0;
        ae_rest = 1'b0;
        dv_pend = 1'b0;
        exp_dout = 8'h00;
        @(negedge clock);
        #1;
        check("t6 rst scl_oe", scl_oe, 0);
        check("t6 rst sda_oe", sda_oe, 0);
        check("t6 rst busy", busy, 0);
        check("t6 rst cmd_ready", cmd_ready, 1);
        check("t6 rst dout", dout, 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
